ram_port_arbiter: RTL and testbench

//  Shares the dual-read/dual-write 256x32 data RAM among N_REQ requesters (fetch, load/store, DMA...).

---
 rtl/ram_arb_pkg.sv | 21 ++
 rtl/ram_port_arbiter_if.sv | 41 ++++
 rtl/ram_arb_rr_pick.sv | 49 ++++
 rtl/ram_port_arbiter.sv | 138 +++++++++++++
 tb/tb_ram_port_arbiter.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_arb_pkg.sv
// Shared types and helpers for the RAM port arbiter.
package ram_arb_pkg;

    localparam int unsigned DEF_ADDR_WIDTH = 8;
    localparam int unsigned DEF_DATA_WIDTH = 32;
    // Wide enough for the largest supported requester count (8).
    localparam int unsigned IDX_WIDTH      = 3;

    typedef struct packed {
        logic                      valid;
        logic                      we;
        logic [IDX_WIDTH-1:0]      req_idx;
        logic [DEF_ADDR_WIDTH-1:0] addr;
        logic [DEF_DATA_WIDTH-1:0] wdata;
    } slot_t;

    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
    endfunction

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Requester-side and RAM-side signal bundle of the RAM port arbiter.
interface ram_port_arbiter_if
    import ram_arb_pkg::*;
#(
    parameter int unsigned N_REQ      = 4,
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
);

    logic [N_REQ-1:0]            req_valid;
    logic [N_REQ-1:0]            req_we;
    logic [N_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [N_REQ*DATA_WIDTH-1:0] req_wdata;
    logic [N_REQ-1:0]            req_ready;
    logic [N_REQ-1:0]            rsp_valid;
    logic [N_REQ*DATA_WIDTH-1:0] rsp_rdata;

    logic [ADDR_WIDTH-1:0]       read_addr1;
    logic [ADDR_WIDTH-1:0]       read_addr2;
    logic [ADDR_WIDTH-1:0]       write_addr1;
    logic [ADDR_WIDTH-1:0]       write_addr2;
    logic [DATA_WIDTH-1:0]       write_data1;
    logic [DATA_WIDTH-1:0]       write_data2;
    logic                        pw1;
    logic                        pw2;
    logic [DATA_WIDTH-1:0]       read_data1;
    logic [DATA_WIDTH-1:0]       read_data2;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, read_data1, read_data2,
        output req_ready, rsp_valid, rsp_rdata, read_addr1, read_addr2,
               write_addr1, write_addr2, write_data1, write_data2, pw1, pw2
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, read_data1, read_data2,
        input  req_ready, rsp_valid, rsp_rdata, read_addr1, read_addr2,
               write_addr1, write_addr2, write_data1, write_data2, pw1, pw2
    );

endinterface

// File: rtl/ram_arb_rr_pick.sv
// Round-robin selection of up to two requesters starting at rr_ptr.
module ram_arb_rr_pick #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned PW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_valid,
    input  logic [PW-1:0]    rr_ptr,
    input  logic [N_REQ-1:0] conflict,
    output logic [PW-1:0]    idx1,
    output logic             vld1,
    output logic [PW-1:0]    idx2,
    output logic             vld2
);

    always_comb begin : pick_first
        logic [PW-1:0] j;
        j    = '0;
        idx1 = '0;
        vld1 = 1'b0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            j = PW'((32'(rr_ptr) + k) % N_REQ);
            if (!vld1 && req_valid[j]) begin
                vld1 = 1'b1;
                idx1 = j;
            end
        end
    end

    // Only the very next valid requester is a slot-2 candidate; a conflict leaves slot 2 empty.
    always_comb begin : pick_second
        logic [PW-1:0] j;
        logic          found;
        j     = '0;
        found = 1'b0;
        idx2  = '0;
        vld2  = 1'b0;
        for (int unsigned k = 1; k < N_REQ; k++) begin
            j = PW'((32'(idx1) + k) % N_REQ);
            if (vld1 && !found && req_valid[j]) begin
                found = 1'b1;
                if (!conflict[j]) begin
                    vld2 = 1'b1;
                    idx2 = j;
                end
            end
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Two-slot round-robin arbiter sharing a dual-read/dual-write RAM among N_REQ requesters.
// Optional per-requester grant counters when RAM_ARB_STATS_EN is defined.
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int unsigned N_REQ      = 4,
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    ram_port_arbiter_if.slave       bus
`ifdef RAM_ARB_STATS_EN
    ,
    output logic [N_REQ*16-1:0]     grant_count
`endif
);

    localparam int unsigned PW = $clog2(N_REQ);

    logic [N_REQ-1:0][ADDR_WIDTH-1:0] addr_a;
    logic [N_REQ-1:0][DATA_WIDTH-1:0] wdata_a;
    logic [N_REQ-1:0][DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [N_REQ-1:0]                 rsp_valid_q, rsp_valid_d;
    logic [N_REQ-1:0]                 conflict, ready;
    logic [PW-1:0]                    rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]                    idx1, idx2;
    logic                             vld1, vld2;
    slot_t                            s1, s2;

    assign addr_a        = bus.req_addr;
    assign wdata_a       = bus.req_wdata;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rdata_q;
    assign bus.req_ready = ready;

    // A slot-2 candidate is blocked only when it and the slot-1 pick write the same address.
    always_comb begin
        conflict = '0;
        for (int i = 0; i < N_REQ; i++) begin
            conflict[i] = bus.req_we[i] && bus.req_we[idx1] && (addr_a[i] == addr_a[idx1]);
        end
    end

    ram_arb_rr_pick #(
        .N_REQ (N_REQ),
        .PW    (PW)
    ) u_pick (
        .req_valid (bus.req_valid),
        .rr_ptr    (rr_ptr_q),
        .conflict  (conflict),
        .idx1      (idx1),
        .vld1      (vld1),
        .idx2      (idx2),
        .vld2      (vld2)
    );

    always_comb begin
        s1         = '0;
        s2         = '0;
        s1.valid   = vld1 && !rst;
        s1.we      = bus.req_we[idx1];
        s1.req_idx = IDX_WIDTH'(idx1);
        s1.addr    = DEF_ADDR_WIDTH'(addr_a[idx1]);
        s1.wdata   = DEF_DATA_WIDTH'(wdata_a[idx1]);
        s2.valid   = vld2 && !rst;
        s2.we      = bus.req_we[idx2];
        s2.req_idx = IDX_WIDTH'(idx2);
        s2.addr    = DEF_ADDR_WIDTH'(addr_a[idx2]);
        s2.wdata   = DEF_DATA_WIDTH'(wdata_a[idx2]);

        bus.pw1         = s1.valid && s1.we;
        bus.pw2         = s2.valid && s2.we;
        bus.read_addr1  = (s1.valid && !s1.we) ? ADDR_WIDTH'(s1.addr) : '0;
        bus.read_addr2  = (s2.valid && !s2.we) ? ADDR_WIDTH'(s2.addr) : '0;
        bus.write_addr1 = bus.pw1 ? ADDR_WIDTH'(s1.addr) : '0;
        bus.write_addr2 = bus.pw2 ? ADDR_WIDTH'(s2.addr) : '0;
        bus.write_data1 = bus.pw1 ? DATA_WIDTH'(s1.wdata) : '0;
        bus.write_data2 = bus.pw2 ? DATA_WIDTH'(s2.wdata) : '0;

        ready = '0;
        for (int i = 0; i < N_REQ; i++) begin
            ready[i] = (s1.valid && idx1 == PW'(i)) || (s2.valid && idx2 == PW'(i));
        end
    end

    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        rsp_valid_d = '0;
        rdata_d     = rdata_q;
        if (s2.valid) begin
            rr_ptr_d = PW'(wrap_inc(32'(idx2), N_REQ));
        end else if (s1.valid) begin
            rr_ptr_d = PW'(wrap_inc(32'(idx1), N_REQ));
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (s1.valid && !s1.we && s1.req_idx == IDX_WIDTH'(i)) begin
                rsp_valid_d[i] = 1'b1;
                rdata_d[i]     = bus.read_data1;
            end
            if (s2.valid && !s2.we && s2.req_idx == IDX_WIDTH'(i)) begin
                rsp_valid_d[i] = 1'b1;
                rdata_d[i]     = bus.read_data2;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q    <= '0;
            rsp_valid_q <= '0;
            rdata_q     <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rdata_d;
        end
    end

`ifdef RAM_ARB_STATS_EN
    logic [N_REQ-1:0][15:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (ready[i] && cnt_q[i] != 16'hFFFF) begin
                    cnt_q[i] <= cnt_q[i] + 16'd1;
                end
            end
        end
    end

    assign grant_count = cnt_q;
`endif

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a reference arbiter/RAM model checked every negedge.
module tb_ram_port_arbiter;

    localparam int N  = 4;
    localparam int AW = 8;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ram_port_arbiter_if #(.N_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

`ifdef RAM_ARB_STATS_EN
    logic [N*16-1:0] grant_count;
`endif

    ram_port_arbiter #(
        .N_REQ      (N),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef RAM_ARB_STATS_EN
        ,
        .grant_count (grant_count)
`endif
    );

    // RAM: combinational read, writes on the falling edge.
    logic [DW-1:0] mem [256];
    assign bus.read_data1 = mem[bus.read_addr1];
    assign bus.read_data2 = mem[bus.read_addr2];
    always @(negedge clk) begin
        if (bus.pw1) mem[bus.write_addr1] <= bus.write_data1;
        if (bus.pw2) mem[bus.write_addr2] <= bus.write_data2;
    end

    int checks = 0;
    int fails  = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state
    int                  m_ptr = 0;
    logic [N-1:0]        m_rsp_valid = '0;
    logic [N*DW-1:0]     m_rdata = '0;
    logic [DW-1:0]       ref_mem [256];

    function automatic logic [AW-1:0] addr_of(input int i);
        return bus.req_addr[i*AW +: AW];
    endfunction

    function automatic logic [DW-1:0] data_of(input int i);
        return bus.req_wdata[i*DW +: DW];
    endfunction

    always @(negedge clk) begin
        int           order[$];
        int           g1, g2, j;
        logic [N-1:0] e_ready;
        logic         e_pw [2];
        logic [AW-1:0] e_ra [2];
        logic [AW-1:0] e_wa [2];
        logic [DW-1:0] e_wd [2];
        int           g [2];

        if (rst) begin
            m_ptr       = 0;
            m_rsp_valid = '0;
            m_rdata     = '0;
        end
        check("rsp_valid", 128'(bus.rsp_valid), 128'(m_rsp_valid));
        check("rsp_rdata", 128'(bus.rsp_rdata), 128'(m_rdata));

        order.delete();
        g1 = -1;
        g2 = -1;
        if (!rst) begin
            for (int k = 0; k < N; k++) begin
                j = (m_ptr + k) % N;
                if (bus.req_valid[j]) order.push_back(j);
            end
        end
        if (order.size() > 0) g1 = order[0];
        if (order.size() > 1) begin
            if (!(bus.req_we[g1] && bus.req_we[order[1]] && addr_of(g1) == addr_of(order[1])))
                g2 = order[1];
        end
        g[0] = g1;
        g[1] = g2;

        e_ready = '0;
        for (int s = 0; s < 2; s++) begin
            e_pw[s] = 1'b0;
            e_ra[s] = '0;
            e_wa[s] = '0;
            e_wd[s] = '0;
            if (g[s] >= 0) begin
                e_ready[g[s]] = 1'b1;
                if (bus.req_we[g[s]]) begin
                    e_pw[s] = 1'b1;
                    e_wa[s] = addr_of(g[s]);
                    e_wd[s] = data_of(g[s]);
                end else begin
                    e_ra[s] = addr_of(g[s]);
                end
            end
        end
        check("req_ready", 128'(bus.req_ready), 128'(e_ready));
        check("slot1", 128'({bus.pw1, bus.read_addr1, bus.write_addr1, bus.write_data1}),
              128'({e_pw[0], e_ra[0], e_wa[0], e_wd[0]}));
        check("slot2", 128'({bus.pw2, bus.read_addr2, bus.write_addr2, bus.write_data2}),
              128'({e_pw[1], e_ra[1], e_wa[1], e_wd[1]}));

        // Writes land before the read capture, so apply them first.
        for (int s = 0; s < 2; s++)
            if (g[s] >= 0 && bus.req_we[g[s]]) ref_mem[addr_of(g[s])] = data_of(g[s]);
        m_rsp_valid = '0;
        for (int s = 0; s < 2; s++) begin
            if (g[s] >= 0 && !bus.req_we[g[s]]) begin
                m_rsp_valid[g[s]]       = 1'b1;
                m_rdata[g[s]*DW +: DW]  = ref_mem[addr_of(g[s])];
            end
        end
        if (g2 >= 0) m_ptr = (g2 + 1) % N;
        else if (g1 >= 0) m_ptr = (g1 + 1) % N;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic we, input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
        bus.req_valid[i]          = 1'b1;
        bus.req_we[i]             = we;
        bus.req_addr[i*AW +: AW]  = a;
        bus.req_wdata[i*DW +: DW] = d;
    endtask

    task automatic clr(input int i);
        bus.req_valid[i] = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_we    = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        for (int a = 0; a < 256; a++) begin
            mem[a]     = '0;
            ref_mem[a] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        check("reset_rsp_valid", 128'(bus.rsp_valid), 128'(0));
        rst = 1'b0;

        // 1: write then read back
        set_req(0, 1'b1, 8'h10, 32'hDEADBEEF);
        #1 check("t1_w_ready", 128'(bus.req_ready), 128'(4'b0001));
        tick(); clr(0); set_req(1, 1'b0, 8'h10, 32'h0);
        #1 check("t1_r_ready", 128'(bus.req_ready), 128'(4'b0010));
        check("t1_raddr", 128'(bus.read_addr1), 128'(8'h10));
        tick(); clr(1);
        #1 check("t1_rsp_valid", 128'(bus.rsp_valid), 128'(4'b0010));
        check("t1_rdata", 128'(bus.rsp_rdata[63:32]), 128'(32'hDEADBEEF));
        tick();
        check("t1_rsp_once", 128'(bus.rsp_valid), 128'(0));

        // 2: four readers, pairs alternate
        do_reset();
        for (int i = 0; i < N; i++) set_req(i, 1'b0, 8'(i + 1), 32'h0);
        #1 check("t2_g0", 128'(bus.req_ready), 128'(4'b0011));
        tick();
        #1 check("t2_g1", 128'(bus.req_ready), 128'(4'b1100));
        check("t2_rsp", 128'(bus.rsp_valid), 128'(4'b0011));
        tick();
        #1 check("t2_g2", 128'(bus.req_ready), 128'(4'b0011));
        tick();
        for (int i = 0; i < N; i++) clr(i);

        // 3: write-write conflict on the same address
        set_req(0, 1'b1, 8'h20, 32'd1);
        set_req(1, 1'b1, 8'h20, 32'd2);
        #1 check("t3_only_r0", 128'(bus.req_ready), 128'(4'b0001));
        check("t3_pw2_off", 128'(bus.pw2), 128'(0));
        tick(); clr(0);
        #1 check("t3_r1", 128'(bus.req_ready), 128'(4'b0010));
        tick(); clr(1);
        check("t3_mem", 128'(mem[8'h20]), 128'(32'd2));

        // 4: same-cycle write and read of one address
        set_req(2, 1'b1, 8'h30, 32'h55);
        set_req(3, 1'b0, 8'h30, 32'h0);
        #1 check("t4_ready", 128'(bus.req_ready), 128'(4'b1100));
        check("t4_pw1", 128'(bus.pw1), 128'(1));
        tick(); clr(2); clr(3);
        #1 check("t4_rdata", 128'(bus.rsp_rdata[127:96]), 128'(32'h55));

        // 5: reset during a read grant cycle
        set_req(1, 1'b0, 8'h10, 32'h0);
        tick(); clr(1);
        check("t5_pre_rsp", 128'(bus.rsp_valid), 128'(4'b0010));
        for (int i = 0; i < N; i++) set_req(i, 1'b0, 8'(i + 8), 32'h0);
        #1 check("t5_ptr2", 128'(bus.req_ready), 128'(4'b1100));
        rst = 1'b1;
        #1 check("t5_rsp_clr", 128'(bus.rsp_valid), 128'(0));
        check("t5_pw", 128'({bus.pw1, bus.pw2}), 128'(0));
        check("t5_ready", 128'(bus.req_ready), 128'(0));
        tick(); tick();
        rst = 1'b0;
        #1 check("t5_ptr0", 128'(bus.req_ready), 128'(4'b0011));
        tick();
        for (int i = 0; i < N; i++) clr(i);

        // Wrap-around pair: pointer at 2, requesters 3 and 0
        set_req(0, 1'b1, 8'h40, 32'hA);
        set_req(3, 1'b1, 8'h41, 32'hB);
        #1 check("wrap_ready", 128'(bus.req_ready), 128'(4'b1001));
        check("wrap_wa1", 128'(bus.write_addr1), 128'(8'h41));
        tick();
        set_req(0, 1'b0, 8'h40, 32'h0);
        set_req(3, 1'b0, 8'h41, 32'h0);
        #1 check("wrap_rd_ready", 128'(bus.req_ready), 128'(4'b1001));
        tick(); clr(0); clr(3);
        check("wrap_rd0", 128'(bus.rsp_rdata[31:0]), 128'(32'hA));
        check("wrap_rd3", 128'(bus.rsp_rdata[127:96]), 128'(32'hB));
        tick();

`ifdef RAM_ARB_STATS_EN
        // 6: grant counter saturation
        do_reset();
        set_req(0, 1'b0, 8'h00, 32'h0);
        repeat (70000) @(posedge clk);
        #1 clr(0);
        check("t6_cnt0", 128'(grant_count[15:0]), 128'(16'hFFFF));
        check("t6_cnt_rest", 128'(grant_count[N*16-1:16]), 128'(0));
        tick();
`endif

        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
